// File: rtl/interleaved_mem_pkg.sv
// Shared definitions for the four-bank interleaved memory.
// Holds bank/row geometry, address field positions, read return latency
// and the types used by the top level and the bank sub-module.
package interleaved_mem_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int READ_LATENCY = 2;
  localparam int BANK_ROWS    = 8192;
  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 16;
  localparam int CNT_W        = 3;

  // Byte address layout: [15:3] row, [2:1] bank, [0] must be zero.
  localparam int BANK_LSB   = 1;
  localparam int BANK_MSB   = 2;
  localparam int ROW_LSB    = 3;
  localparam int ROW_MSB    = 15;
  localparam int BANK_IDX_W = BANK_MSB - BANK_LSB + 1;
  localparam int ROW_W      = ROW_MSB - ROW_LSB + 1;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [ROW_W-1:0]      row_t;
  typedef logic [BANK_IDX_W-1:0] bank_idx_t;

  typedef struct packed {
    logic  valid;
    word_t data;
  } rd_ret_t;

  function automatic bank_idx_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_MSB:BANK_LSB];
  endfunction

  function automatic row_t row_of(input logic [ADDR_W-1:0] a);
    return a[ROW_MSB:ROW_LSB];
  endfunction

endpackage

// File: rtl/interleaved_mem_bank.sv
// One memory bank: 8192 x 16 array, busy down-counter and a single
// write/read port.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset (counter only, array untouched)
//   acc_i    - access accepted for this bank this cycle
//   wr_i     - accepted access is a write
//   row_i    - row to access
//   wdata_i  - write data
//   rdata_o  - current contents of row_i (combinational)
//   busy_o   - bank occupied
module mem_bank
  import interleaved_mem_pkg::*;
#(
  parameter int BUSY_CYCLES = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  acc_i,
  input  logic  wr_i,
  input  row_t  row_i,
  input  word_t wdata_i,
  output word_t rdata_o,
  output logic  busy_o
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(BUSY_CYCLES);

  word_t            mem_q [BANK_ROWS];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (acc_i) begin
      cnt_d = LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Array has no reset so contents survive a reset of the controller.
  // acc_i is already suppressed while rst is low.
  always_ff @(posedge clk) begin
    if (acc_i && wr_i) begin
      mem_q[row_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[row_i];
  assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/interleaved_mem.sv
// Four-way interleaved memory with per-bank busy tracking.
// Decodes requests, flags illegal ones, stalls requests to busy banks,
// and returns read data through a fixed two-cycle pipeline.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset
//   addr     - byte address ([2:1] bank, [15:3] row)
//   data_in  - write data
//   wr, rd   - write / read request
//   data_out - read data in the return cycle, 0 otherwise
//   stall    - request refused because target bank is busy
//   busy     - per-bank occupied flags
//   err      - request is illegal (rd&wr, or odd address)
module interleaved_mem
  import interleaved_mem_pkg::*;
#(
  parameter int BUSY_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DATA_W-1:0]    data_out,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  bank_idx_t            bank_sel;
  row_t                 row;
  logic                 req;
  logic                 illegal;
  logic                 accept;
  logic [NUM_BANKS-1:0] acc_vec;
  word_t                rdata [NUM_BANKS];
  rd_ret_t              pipe_q [READ_LATENCY];
  rd_ret_t              pipe_d [READ_LATENCY];

  assign bank_sel = bank_of(addr);
  assign row      = row_of(addr);
  assign req      = rd | wr;
  assign illegal  = (rd & wr) | (req & addr[0]);

  // Everything is masked during reset so nothing is flagged or accepted.
  assign err    = rst & illegal;
  assign stall  = rst & req & ~illegal & busy[bank_sel];
  assign accept = rst & req & ~illegal & ~busy[bank_sel];

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign acc_vec[i] = accept && (bank_sel == bank_idx_t'(i));

    mem_bank #(
      .BUSY_CYCLES(BUSY_CYCLES)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .acc_i  (acc_vec[i]),
      .wr_i   (wr),
      .row_i  (row),
      .wdata_i(data_in),
      .rdata_o(rdata[i]),
      .busy_o (busy[i])
    );
  end

  // Stage 0 captures the word as it stands in the accept cycle; only one
  // access is accepted per cycle, so no write can race it.
  always_comb begin
    pipe_d[0].valid = accept & rd;
    pipe_d[0].data  = rdata[bank_sel];
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign data_out = pipe_q[READ_LATENCY-1].valid ? pipe_q[READ_LATENCY-1].data : '0;

endmodule

// File: tb/tb_interleaved_mem.sv
// Directed bench for interleaved_mem: inputs driven 1 ns after the rising
// edge, outputs checked 2 ns after it.
module tb_interleaved_mem;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  interleaved_mem #(.BUSY_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .wr      (wr),
    .rd      (rd),
    .data_out(data_out),
    .stall   (stall),
    .busy    (busy),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd = 1'b0;
    wr = 1'b0;
    addr = 16'h0000;
    data_in = 16'h0000;
  endtask

  task automatic test_reset();
    rst = 1'b0; rd = 1'b1; wr = 1'b1; addr = 16'h0001; data_in = 16'hFFFF;
    tick();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
    rd = 1'b0; wr = 1'b1; addr = 16'h0000;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall_wr: got %b expected 0", stall); end
    tick();
    #1;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL rst_busy: got %b expected 0000", busy); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rst_data_out: got %h expected 0000", data_out); end
    rst = 1'b1;
    idle();
    tick();
    #1;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL rst_no_accept: got %b expected 0000", busy); end
  endtask

  task automatic test_basic();
    wr = 1'b1; addr = 16'h0010; data_in = 16'hBEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_wr_stall: got %b expected 0", stall); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_wr_err: got %b expected 0", err); end
    tick();
    idle();
    #1;
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL basic_busy_t1: got %b expected 0001", busy); end
    tick(); tick(); tick();
    #1;
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL basic_busy_t4: got %b expected 0001", busy); end
    tick();
    rd = 1'b1; addr = 16'h0010;
    #1;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL basic_busy_t5: got %b expected 0000", busy); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL basic_rd_stall: got %b expected 0", stall); end
    tick();
    idle();
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL basic_rd_t1: got %h expected 0000", data_out); end
    tick();
    #1;
    checks++; if (data_out !== 16'hBEEF) begin errors++; $display("FAIL basic_rd_t2: got %h expected beef", data_out); end
    tick();
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL basic_rd_t3: got %h expected 0000", data_out); end
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; addr = 16'(i * 2); data_in = 16'(16'h1111 * (i + 1));
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_%0d: got %b expected 0", i, stall); end
      tick();
    end
    idle();
    #1;
    checks++; if (busy !== 4'b1111) begin errors++; $display("FAIL b2b_busy_t4: got %b expected 1111", busy); end
    tick();
    #1;
    checks++; if (busy !== 4'b1110) begin errors++; $display("FAIL b2b_busy_t5: got %b expected 1110", busy); end
    repeat (6) tick();
  endtask

  task automatic test_stall();
    wr = 1'b1; addr = 16'h0008; data_in = 16'h5A5A;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_wr: got %b expected 0", stall); end
    tick();
    wr = 1'b0; rd = 1'b1; addr = 16'h0000; data_in = 16'h0000;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_t%0d: got %b expected 1", k, stall); end
      tick();
    end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_t5: got %b expected 0", stall); end
    tick();
    idle();
    #1;
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL stall_busy_t6: got %b expected 0001", busy); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL stall_rd_t6: got %h expected 0000", data_out); end
    tick();
    #1;
    checks++; if (data_out !== 16'h1111) begin errors++; $display("FAIL stall_rd_t7: got %h expected 1111", data_out); end
    tick();
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL stall_rd_t8: got %h expected 0000", data_out); end
    repeat (5) tick();
  endtask

  task automatic test_err();
    wr = 1'b1; addr = 16'h0002; data_in = 16'h2222;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_legal: got %b expected 0", err); end
    tick();
    wr = 1'b1; rd = 1'b1; addr = 16'h0002;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_rdwr: got %b expected 1", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL err_rdwr_stall: got %b expected 0", stall); end
    checks++; if (busy !== 4'b0010) begin errors++; $display("FAIL err_busy_a: got %b expected 0010", busy); end
    tick();
    wr = 1'b0; rd = 1'b1; addr = 16'h0003;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_odd_rd: got %b expected 1", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL err_odd_rd_stall: got %b expected 0", stall); end
    tick();
    wr = 1'b1; rd = 1'b0; addr = 16'h0001; data_in = 16'hDEAD;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_odd_wr: got %b expected 1", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL err_odd_wr_stall: got %b expected 0", stall); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL err_no_pulse_c: got %h expected 0000", data_out); end
    tick();
    idle();
    #1;
    checks++; if (busy !== 4'b0010) begin errors++; $display("FAIL err_busy_d: got %b expected 0010", busy); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL err_no_pulse_d: got %h expected 0000", data_out); end
    tick();
    #1;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL err_busy_e: got %b expected 0000", busy); end
    rd = 1'b1; addr = 16'h0003;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_odd_free: got %b expected 1", err); end
    tick();
    idle();
    #1;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL err_busy_f: got %b expected 0000", busy); end
    tick();
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL err_no_pulse_g: got %h expected 0000", data_out); end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    wr = 1'b1; addr = 16'h0020; data_in = 16'hC0DE;
    tick();
    idle();
    repeat (5) tick();
    rd = 1'b1; addr = 16'h0020;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_rd_stall: got %b expected 0", stall); end
    tick();
    idle();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL rmid_busy_t1: got %b expected 0001", busy); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL rmid_busy_t2: got %b expected 0000", busy); end
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rmid_dropped_t2: got %h expected 0000", data_out); end
    tick();
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rmid_dropped_t3: got %h expected 0000", data_out); end
    rd = 1'b1; addr = 16'h0020;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_reread_stall: got %b expected 0", stall); end
    tick();
    idle();
    tick();
    #1;
    checks++; if (data_out !== 16'hC0DE) begin errors++; $display("FAIL rmid_reread: got %h expected c0de", data_out); end
    repeat (5) tick();
  endtask

  task automatic test_readback();
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        rd = 1'b1; addr = 16'(i * 2);
      end else begin
        idle();
      end
      #1;
      if (i < 4) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rb_stall_%0d: got %b expected 0", i, stall); end
      end
      if (i >= 2) begin
        checks++;
        if (data_out !== 16'(16'h1111 * (i - 1))) begin
          errors++; $display("FAIL rb_data_%0d: got %h expected %h", i, data_out, 16'(16'h1111 * (i - 1)));
        end
      end
      tick();
    end
    repeat (6) tick();
    rd = 1'b1; addr = 16'h0008;
    tick();
    idle();
    tick();
    #1;
    checks++; if (data_out !== 16'h5A5A) begin errors++; $display("FAIL rb_row1: got %h expected 5a5a", data_out); end
    tick();
    #1;
    checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL rb_row1_after: got %h expected 0000", data_out); end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_err();
    test_reset_mid();
    test_readback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interleaved_mem.md
INTERLEAVED_MEM -- requirements
Module: interleaved_mem

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 4: cycles a bank stays busy after accepting an access; legal range 3..7.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port addr, input, 16: byte address; addr[2:1] selects the bank, addr[15:3] selects the row.
REQ-005 SHALL have port data_in, input, 16: write data.
REQ-006 SHALL have port wr, input, 1: write request.
REQ-007 SHALL have port rd, input, 1: read request.
REQ-008 SHALL have port data_out, output, 16: read data, valid only in the return cycle, 0 otherwise.
REQ-009 SHALL have port stall, output, 1: the request was not accepted because the target bank is busy.
REQ-010 SHALL have port busy, output, 4: bit i is 1 while bank i is occupied.
REQ-011 SHALL have port err, output, 1: the request is illegal.

Function
REQ-012 SHALL contain four banks of 8192 x 16-bit words; word location = bank addr[2:1], row addr[15:3].
REQ-013 SHALL flag err combinationally when (rd & wr), or when (rd | wr) & addr[0].
REQ-014 SHALL never accept an err request: no state change and stall=0.
REQ-015 SHALL assert stall combinationally when (rd | wr) & ~err & busy[addr[2:1]].
REQ-016 SHALL accept a request in cycle T when (rd | wr) & ~err & ~stall.
REQ-017 SHALL hold busy[bank]=1 in cycles T+1 through T+BUSY_CYCLES for an access accepted at T, then return it to 0.
REQ-018 SHALL write data_in into the addressed word at the edge ending cycle T for an accepted write; data_out is unaffected.
REQ-019 SHALL present, for an accepted read at T, the word as stored at the end of T on data_out during cycle T+2 only (fixed latency 2).
REQ-020 SHALL accept accesses to different free banks in consecutive cycles; up to four banks may be busy at once.
REQ-021 SHALL return at most one read per cycle; overlap is impossible because accepts are at most one per cycle.
REQ-022 SHALL stall a request to a bank that becomes free at T+BUSY_CYCLES+1 through cycle T+BUSY_CYCLES and accept it in cycle T+BUSY_CYCLES+1.
REQ-023 SHALL keep the requester responsible for holding addr, data_in, rd and wr stable while stall=1; the block keeps no record of stalled requests.
REQ-024 SHALL track each bank with a 3-bit down-counter: load BUSY_CYCLES on accept, decrement to 0; busy[i] = (count_i != 0).
REQ-025 SHALL carry the read return in a 2-stage pipeline of {valid, data}.

Reset
REQ-026 SHALL, with rst=0 at a rising edge, clear all bank counters (busy=4'b0000) and the read pipeline, making data_out=0 next cycle.
REQ-027 SHALL drop an in-flight read on reset mid-operation; its data never appears.
REQ-028 SHALL not accept requests and SHALL keep stall=0 and err=0 while rst=0.
REQ-029 SHALL not alter memory array contents on reset.

Structure
REQ-030 SHALL place NUM_BANKS=4, READ_LATENCY=2 and BANK_ROWS=8192 in the shared memory package, together with the bank-index and row field positions.
REQ-031 SHALL use one sub-module, mem_bank (array + busy counter + write/read port), instantiated four times; top level holds decode, err/stall logic and the return pipeline.

Verification
REQ-032 SHALL cover: write 0xBEEF @0x0010, idle 4 cycles, read @0x0010 at T -> data_out=0xBEEF in T+2 only, 0 in T+1 and T+3.
REQ-033 SHALL cover: writes at T..T+3 to 0x0000/0x0002/0x0004/0x0006 -> no stall, busy=4'b1111 at T+4, busy[0]=0 at T+5.
REQ-034 SHALL cover: write @0x0008 at T, then hold a read @0x0000 -> stall=1 in T+1..T+4, accepted at T+5, data_out = prior @0x0000 contents at T+7.
REQ-035 SHALL cover: rd=wr=1 @0x0002, and rd @0x0003 -> err=1, stall=0, busy unchanged, no data_out pulse.
REQ-036 SHALL cover: read @0x0020 at T, rst=0 at T+1 -> busy=0 and data_out=0 from T+2, and a later read of @0x0020 returns the unchanged contents.
